// File: rtl/pmu_ctrl.sv
// rtl/pmu_ctrl.sv - power-management unit: keyed shutdown/reset commands, watchdog, reset cause
module pmu_ctrl #(
  parameter int          addr_w = 12,
  parameter logic [23:0] key    = 24'hB0A5A5,
  parameter int          wdt_w  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bus_re,
  input  logic [3:0]        bus_we,
  input  logic [addr_w-1:0] bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic              bus_ready,
  output logic [31:0]       bus_rdata,
  output logic              shdn_req,
  output logic              rst_req
);

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_wait = 2'd1,
    st_off  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [15:0]        delay_reg;
  logic [15:0]        dly_cnt;
  logic               kind_shdn;
  logic [wdt_w-1:0]   wdt_cnt;
  logic               wdt_armed;
  logic [1:0]         cause;
  logic               err;

  logic [1:0]         sel;
  logic               wr;
  logic               wr_cmd;
  logic               wr_delay;
  logic               wr_wdt;
  logic               wr_status;
  logic               cmd_ok;
  logic               accept;
  logic               fire;
  logic               wdt_exp;
  logic               do_rst;
  logic               pend;
  logic [wdt_w-1:0]   wdt_wval;
  logic [31:0]        status;
  logic               unused_addr;

  assign bus_ready = 1'b1;
  assign sel       = bus_addr[3:2];
  assign wr        = |bus_we;
  assign wr_cmd    = wr && (sel == 2'd0);
  assign wr_delay  = wr && (sel == 2'd1);
  assign wr_wdt    = wr && (sel == 2'd2);
  assign wr_status = wr && (sel == 2'd3);
  assign wdt_wval  = bus_wdata[wdt_w-1:0];
  assign unused_addr = ^{bus_addr[addr_w-1:4], bus_addr[1:0]};

  assign pend    = (state != st_idle);
  assign cmd_ok  = (bus_wdata[31:8] == key) &&
                   ((bus_wdata[1:0] == 2'b01) || (bus_wdata[1:0] == 2'b10)) && !pend;
  assign fire    = (state == st_wait) && (dly_cnt == 16'd0);
  // A WDT write in the expiry cycle reloads the counter instead of expiring
  assign wdt_exp = wdt_armed && (wdt_cnt == wdt_w'(1)) && !wr_wdt;
  assign do_rst  = wdt_exp || (fire && !kind_shdn);
  // A command landing on the same edge as a reset is swallowed by that reset
  assign accept  = wr_cmd && cmd_ok && !do_rst;
  assign status  = {26'd0, wdt_armed, err, cause, pend && kind_shdn, pend};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= st_idle;
    else        state <= state_nx;
  end

  // Next-state: command accept, fire, and reset returning everything to idle
  always_comb begin
    state_nx = state;
    case (state)
      st_idle: if (accept) state_nx = st_wait;
      st_wait: if (fire) state_nx = kind_shdn ? st_off : st_idle;
      st_off:  state_nx = st_off;
      default: state_nx = st_idle;
    endcase
    if (do_rst) state_nx = st_idle;
  end

  // Request outputs, delay counter and latched command kind
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_req   <= 1'b0;
      shdn_req  <= 1'b0;
      dly_cnt   <= 16'd0;
      kind_shdn <= 1'b0;
    end else begin
      rst_req <= do_rst;
      if (do_rst)                  shdn_req <= 1'b0;
      else if (fire && kind_shdn)  shdn_req <= 1'b1;
      if (accept) begin
        dly_cnt   <= delay_reg;
        kind_shdn <= bus_wdata[1];
      end else if ((state == st_wait) && (dly_cnt != 16'd0)) begin
        dly_cnt <= dly_cnt - 16'd1;
      end
    end
  end

  // Software-visible registers: DELAY, watchdog, reset cause, sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay_reg <= 16'd0;
      wdt_cnt   <= '0;
      wdt_armed <= 1'b0;
      cause     <= 2'b00;
      err       <= 1'b0;
    end else begin
      if (do_rst)        delay_reg <= 16'd0;
      else if (wr_delay) delay_reg <= bus_wdata[15:0];

      if (do_rst) begin
        wdt_cnt   <= '0;
        wdt_armed <= 1'b0;
      end else if (wr_wdt) begin
        wdt_cnt   <= wdt_wval;
        wdt_armed <= (wdt_wval != '0);
      end else if (wdt_armed && (wdt_cnt != '0)) begin
        wdt_cnt <= wdt_cnt - wdt_w'(1);
      end

      if (wdt_exp)     cause <= 2'b10;
      else if (do_rst) cause <= 2'b01;

      if (wr_cmd && !cmd_ok)              err <= 1'b1;
      else if (wr_status && bus_wdata[4]) err <= 1'b0;
    end
  end

  // Registered read port; holds its value between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_rdata <= 32'd0;
    end else if (bus_re) begin
      case (sel)
        2'd0:    bus_rdata <= 32'd0;
        2'd1:    bus_rdata <= {16'd0, delay_reg};
        2'd2:    bus_rdata <= 32'(wdt_cnt);
        default: bus_rdata <= status;
      endcase
    end
  end

endmodule

// File: tb/tb_pmu_ctrl.sv
// tb/tb_pmu_ctrl.sv - self-checking bench for pmu_ctrl with an event-time reference model
module tb_pmu_ctrl;

  localparam logic [23:0] KEY = 24'hB0A5A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_re;
  logic [3:0]  bus_we;
  logic [11:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        shdn_req;
  logic        rst_req;

  pmu_ctrl #(.addr_w(12), .key(KEY), .wdt_w(24)) dut (
    .clk(clk), .rst_n(rst_n), .bus_re(bus_re), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
    .bus_rdata(bus_rdata), .shdn_req(shdn_req), .rst_req(rst_req)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc_no = 0;
  int n_rst = 0;
  int last_rst_cyc = -1;
  bit shdn_seen = 0;

  // Reference model: pending command and watchdog kept as absolute edge numbers
  bit          m_pend, m_kind, m_off, m_armed, m_err, m_rst;
  int          m_fire_edge, m_wdt_edge;
  logic [15:0] m_delay;
  logic [1:0]  m_cause;
  logic [31:0] m_rd;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h at cycle %0d", tag, act, exp, cyc_no);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_kind = 0; m_off = 0; m_armed = 0; m_err = 0; m_rst = 0;
    m_fire_edge = 0; m_wdt_edge = 0; m_delay = '0; m_cause = 2'b00; m_rd = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] s, input int now);
    case (s)
      2'd0: return 32'd0;
      2'd1: return {16'd0, m_delay};
      2'd2: return m_armed ? 32'(m_wdt_edge - now) : 32'd0;
      default: return {26'd0, m_armed, m_err, m_cause, m_pend && m_kind, m_pend};
    endcase
  endfunction

  // Advance the model across edge e using pre-edge state and the sampled bus inputs
  task automatic model_step(input logic re, input logic [3:0] we, input logic [11:0] a,
                            input logic [31:0] d);
    int e;
    logic [1:0] s;
    bit wr, wexp, fire, rst, ok;
    e = cyc_no;
    s = a[3:2];
    wr = (we != 4'd0);
    if (re) m_rd = model_read(s, e - 1);
    wexp = m_armed && (e == m_wdt_edge) && !(wr && s == 2'd2);
    fire = m_pend && !m_off && (e == m_fire_edge);
    rst  = wexp || (fire && !m_kind);
    ok   = (d[31:8] == KEY) && (d[1:0] == 2'b01 || d[1:0] == 2'b10) && !m_pend;
    m_rst = rst;
    if (fire && m_kind && !rst) m_off = 1;
    if (wr && s == 2'd0) begin
      if (!ok) m_err = 1;
      else if (!rst) begin
        m_pend = 1;
        m_kind = d[1];
        m_fire_edge = e + int'(m_delay) + 1;
      end
    end
    if (wr && s == 2'd1) m_delay = d[15:0];
    if (wr && s == 2'd2) begin
      m_armed = (d[23:0] != 24'd0);
      m_wdt_edge = e + int'(d[23:0]);
    end
    if (wr && s == 2'd3 && d[4]) m_err = 0;
    if (rst) begin
      m_pend = 0; m_off = 0; m_armed = 0; m_delay = '0;
      m_cause = wexp ? 2'b10 : 2'b01;
    end
  endtask

  task automatic cyc(input logic re, input logic [3:0] we, input logic [11:0] a,
                     input logic [31:0] d);
    bus_re = re; bus_we = we; bus_addr = a; bus_wdata = d;
    @(posedge clk);
    cyc_no++;
    model_step(re, we, a, d);
    #1;
    chk("rst_req", {31'd0, rst_req}, {31'd0, m_rst});
    chk("shdn_req", {31'd0, shdn_req}, {31'd0, m_off});
    chk("bus_rdata", bus_rdata, m_rd);
    if (rst_req) begin n_rst++; last_rst_cyc = cyc_no; end
    if (shdn_req) shdn_seen = 1;
    bus_re = 0; bus_we = 4'd0;
  endtask

  task automatic wr(input logic [1:0] s, input logic [31:0] d);
    cyc(1'b0, 4'hF, {8'h00, s, 2'b00}, d);
  endtask

  task automatic rd(input logic [1:0] s);
    cyc(1'b1, 4'h0, {8'h00, s, 2'b00}, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 12'd0, 32'd0);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk({tag, "_shdn"}, {31'd0, shdn_req}, 32'd0);
    chk({tag, "_rst"}, {31'd0, rst_req}, 32'd0);
    chk({tag, "_rdata"}, bus_rdata, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    int n0, k, r;
    logic [1:0] s;
    logic [31:0] d;
    rst_n = 0; bus_re = 0; bus_we = 4'd0; bus_addr = '0; bus_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_shdn", {31'd0, shdn_req}, 32'd0);
    chk("reset_rst", {31'd0, rst_req}, 32'd0);
    chk("reset_rdata", bus_rdata, 32'd0);
    chk("bus_ready", {31'd0, bus_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1;
    rd(2'd1); chk("reset_delay", bus_rdata, 32'd0);
    rd(2'd2); chk("reset_wdt", bus_rdata, 32'd0);
    rd(2'd3); chk("reset_status", bus_rdata, 32'd0);

    // Delayed software reset
    wr(2'd1, 32'd5);
    wr(2'd0, 32'hB0A5A501);
    n0 = cyc_no;
    for (int i = 0; i < 20 && !rst_req; i++) idle(1);
    chk("t1_latency", 32'(last_rst_cyc - n0), 32'd6);
    rd(2'd3);
    chk("t1_cause", {30'd0, bus_rdata[3:2]}, 32'd1);
    chk("t1_pend", {31'd0, bus_rdata[0]}, 32'd0);

    // Immediate shutdown, rejected second command, watchdog wakes it
    wr(2'd1, 32'd0);
    wr(2'd0, 32'hB0A5A502);
    idle(1);
    chk("t2_shdn_rise", {31'd0, shdn_req}, 32'd1);
    idle(3);
    wr(2'd0, 32'hB0A5A502);
    rd(2'd3);
    chk("t2_err", {31'd0, bus_rdata[4]}, 32'd1);
    chk("t2_shdn_hold", {31'd0, shdn_req}, 32'd1);
    n0 = n_rst;
    wr(2'd2, 32'd3);
    idle(4);
    chk("t2_wdt_pulses", 32'(n_rst - n0), 32'd1);
    chk("t2_shdn_fall", {31'd0, shdn_req}, 32'd0);

    // Wrong key, then clearing ERR
    wr(2'd3, 32'h10);
    n0 = n_rst;
    wr(2'd0, 32'h12345601);
    idle(3);
    rd(2'd3);
    chk("t3_err_set", {31'd0, bus_rdata[4]}, 32'd1);
    chk("t3_no_req", 32'(n_rst - n0), 32'd0);
    wr(2'd3, 32'h10);
    rd(2'd3);
    chk("t3_err_clr", {31'd0, bus_rdata[4]}, 32'd0);

    // Kicked watchdog stays quiet, then expires
    n0 = n_rst;
    wr(2'd2, 32'd10);
    for (int i = 0; i < 12; i++) begin idle(7); wr(2'd2, 32'd10); end
    k = cyc_no;
    chk("t4_kicked", 32'(n_rst - n0), 32'd0);
    for (int i = 0; i < 20 && !rst_req; i++) idle(1);
    chk("t4_latency", 32'(last_rst_cyc - k), 32'd10);
    rd(2'd3);
    chk("t4_cause", {30'd0, bus_rdata[3:2]}, 32'd2);
    chk("t4_disarmed", {31'd0, bus_rdata[5]}, 32'd0);

    // Shutdown fire coinciding with watchdog expiry
    wr(2'd1, 32'd4);
    wr(2'd2, 32'd10);
    idle(4);
    n0 = n_rst;
    shdn_seen = 0;
    wr(2'd0, 32'hB0A5A502);
    idle(12);
    chk("t5_pulses", 32'(n_rst - n0), 32'd1);
    chk("t5_no_shdn", {31'd0, shdn_seen}, 32'd0);
    rd(2'd3);
    chk("t5_cause", {30'd0, bus_rdata[3:2]}, 32'd2);

    // Power-on reset in the middle of WAIT and of OFF
    wr(2'd1, 32'd10);
    wr(2'd0, 32'hB0A5A501);
    idle(3);
    async_reset("t6_wait");
    n0 = n_rst;
    idle(20);
    chk("t6_wait_quiet", 32'(n_rst - n0), 32'd0);
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB0A5A502);
    idle(5);
    chk("t6_off_entered", {31'd0, shdn_req}, 32'd1);
    async_reset("t6_off");
    idle(10);
    chk("t6_off_quiet", 32'(n_rst - n0), 32'd0);
    rd(2'd3);
    chk("t6_status", bus_rdata, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      d = $urandom;
      if (r < 8) begin
        s = 2'd0; d = {KEY, 6'($urandom), 2'($urandom)};
      end else if (r < 10) begin
        s = 2'd0;
      end else if (r < 16) begin
        s = 2'd1; d = {16'($urandom), 16'($urandom_range(0, 20))};
      end else if (r < 22) begin
        s = 2'd2; d = {8'($urandom), 24'($urandom_range(0, 40))};
        if ($urandom_range(0, 4) == 0) d[23:0] = 24'd0;
      end else if (r < 25) begin
        s = 2'd3;
      end else begin
        s = 2'($urandom);
      end
      cyc((r >= 25) || ($urandom_range(0, 3) == 0),
          (r < 25) ? 4'($urandom_range(1, 15)) : 4'd0,
          {4'($urandom), s, 2'($urandom)}, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pmu_ctrl.md
# pmu_ctrl

Memory-mapped power-management unit. It is the responder end of the PMU request lines that the board top consumes: `shdn_req` gates the core clock off and `rst_req` restarts the core. The block sits on the peripheral bus and turns key-protected software commands and a watchdog timeout into delayed, prioritised shutdown and reset requests. It also records the cause of the last reset so firmware can read it after restart.

## Interface
Parameters:
- `addr_w`, 12: bus address width; bits [3:2] select the register, the other bits are ignored.
- `key`, 24'hB0A5A5: unlock key, compared with CMD `wdata[31:8]`.
- `wdt_w`, 24: watchdog counter width.

Ports:
- `clk  in  1  system clock; every register is clocked on its rising edge.`
- `rst_n  in  1  power-on reset, asynchronous, active-low.`
- `bus_re  in  1  read strobe.`
- `bus_we  in  4  byte write enables; any nonzero value is a full-word write.`
- `bus_addr  in  addr_w  byte address.`
- `bus_wdata  in  32  write data.`
- `bus_ready  out  1  tied to 1.`
- `bus_rdata  out  32  read data, registered.`
- `shdn_req  out  1  shutdown request, level.`
- `rst_req  out  1  soft-reset request, one-cycle pulse.`

## Operation
Registers, selected by `bus_addr[3:2]`:
- **0 CMD** (write-only, reads 0).
  - Accepted only if `wdata[31:8]==key`, `wdata[1:0]` is 01 (reset) or 10 (shutdown), and nothing is pending.
  - On acceptance: pending is set, the pending kind is latched, and the delay counter is loaded from DELAY.
  - On rejection: sticky ERR is set and nothing else changes.
- **1 DELAY** (rw, bits [15:0]): number of delay cycles for the next accepted command.
- **2 WDT**.
  - Write: nonzero loads the counter and arms the watchdog; 0 disarms it.
  - Read: returns the current count.
- **3 STATUS**.
  - [0] pending; [1] pending kind is shutdown; [3:2] last reset cause (00 power-on, 01 software, 10 watchdog); [4] ERR; [5] WDT armed.
  - Writing 1 to bit 4 clears ERR. All other bits are read-only.

State machine:
- **IDLE**: accepted CMD goes to WAIT.
- **WAIT**: the delay counter decrements each cycle. When it is 0, the command fires.
  - Reset kind: `rst_req` pulses, cause becomes 01, back to IDLE.
  - Shutdown kind: `shdn_req` is set, go to OFF.
- **OFF**: `shdn_req` stays high. CMD writes are rejected (ERR). Only a reset request or `rst_n` leaves this state.

Watchdog:
- While armed, the counter decrements each cycle.
- On the 1→0 transition (expiry), `rst_req` pulses and cause becomes 10.
- A write to WDT in the same cycle as expiry wins: the counter reloads and there is no reset.
- The watchdog keeps running in WAIT and in OFF.

Every `rst_req` pulse, whatever its source:
- clears pending and `shdn_req`, disarms the WDT, and sets DELAY to 0;
- keeps the cause and ERR;
- returns the state to IDLE on the next cycle.

Simultaneous events:
- Watchdog expiry and command fire in the same cycle: reset wins, cause is 10, and a pending shutdown is dropped.
- CMD write in the same cycle as a fire: the write is treated as "pending", so it is rejected and sets ERR.

Arithmetic:
- Counters decrement without wrap: a counter at 0 stays at 0.
- DELAY writes take `wdata[15:0]`. WDT writes take `wdata[wdt_w-1:0]`; upper bits are ignored.

## Timing
- Values while `rst_n` is low: `shdn_req`=0, `rst_req`=0, `bus_rdata`=0, state IDLE, DELAY=0, WDT disarmed at 0, cause=00, ERR=0.
- Read latency: `bus_rdata` is valid at the edge after `bus_re` is sampled. It holds its value until the next read.
- CMD accepted at edge N with DELAY=d: `rst_req` is high, or `shdn_req` rises, in the cycle after edge N+d+1.
  - d=0 gives 1 cycle of latency.
- WDT written with w at edge N: expiry pulse in the cycle after edge N+w.
- `rst_req` is high for exactly one cycle. `shdn_req` falls in the same cycle that `rst_req` is high.
- Reads of STATUS reflect state as of the read edge. A same-cycle write is not visible in that read.

## Test plan
- DELAY=5, CMD=0xB0A5A501 → `rst_req` pulses exactly 6 cycles after the write; STATUS[3:2]=01 and STATUS[0]=0.
- CMD=0xB0A5A502 with DELAY=0 → `shdn_req` goes high 1 cycle later and stays high. A second CMD sets STATUS[4]=1. WDT=3 then gives a `rst_req` pulse and `shdn_req`=0.
- Wrong key 0x12345601 → no request and STATUS[4]=1. Writing 0x10 to STATUS → STATUS[4]=0.
- WDT=10, kicked with 10 every 8 cycles for 100 cycles → no `rst_req`. Stop kicking → pulse 10 cycles after the last kick, cause=10, STATUS[5]=0.
- DELAY=4, shutdown CMD issued so that it fires in the same cycle as WDT expiry → single `rst_req`, `shdn_req` never rises, cause=10.
- `rst_n` asserted mid-WAIT and mid-OFF → all outputs and registers return immediately to their reset values, and no request is produced after `rst_n` is released.
